// File: rtl/key_sched_ctrl_if.sv
// Key-schedule controller bus: key intake, shared sub-key step unit, round-key
// read port and status. The controller takes the slave side.
interface key_sched_ctrl_if #(
  parameter int WORD_LEN = 32
);
  logic [255:0]         key_in;
  logic                 key_valid;
  logic                 key_ready;

  logic                 step_req;
  logic                 step_opcode;
  logic [WORD_LEN-1:0]  step_rcon;
  logic [255:0]         step_data;
  logic                 step_ack;
  logic [127:0]         step_result;

  logic                 rk_rd_en;
  logic [3:0]           rk_rd_idx;
  logic [127:0]         rk_rd_data;
  logic                 rk_rd_valid;
  logic                 rk_rd_err;

  logic                 busy;
  logic                 sched_done;

  modport slave (
    input  key_in, key_valid, step_ack, step_result, rk_rd_en, rk_rd_idx,
    output key_ready, step_req, step_opcode, step_rcon, step_data,
           rk_rd_data, rk_rd_valid, rk_rd_err, busy, sched_done
  );

  modport master (
    output key_in, key_valid, step_ack, step_result, rk_rd_en, rk_rd_idx,
    input  key_ready, step_req, step_opcode, step_rcon, step_data,
           rk_rd_data, rk_rd_valid, rk_rd_err, busy, sched_done
  );
endinterface

// File: rtl/key_sched_ctrl.sv
// AES-256 key-schedule sequencer: feeds a shared step unit one round key at a
// time, stores the results, and serves registered reads of generated keys.
module key_sched_ctrl #(
  parameter int NUM_RK   = 15,
  parameter int WORD_LEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  key_sched_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0]          LAST  = 4'(NUM_RK - 1);
  localparam logic [WORD_LEN-1:0] RCON0 = WORD_LEN'(32'h0100_0000);

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] rk [NUM_RK];
  logic         accept;
  logic         rd_legal;

  assign accept = bus.key_valid && bus.key_ready;

  // A key is readable only once written; RK[cnt] is still in flight while busy.
  assign rd_legal = (bus.busy && (bus.rk_rd_idx < cnt)) ||
                    ((state == DONE) && (bus.rk_rd_idx <= LAST));

  always_ff @(posedge clk) begin
    if (accept) begin
      rk[0] <= bus.key_in[255:128];
      rk[1] <= bus.key_in[127:0];
    end else if ((state == WAIT) && bus.step_ack) begin
      rk[cnt] <= bus.step_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.key_ready   <= 1'b1;
      bus.busy        <= 1'b0;
      bus.sched_done  <= 1'b0;
      bus.step_req    <= 1'b0;
      bus.step_opcode <= 1'b0;
      bus.step_rcon   <= '0;
      bus.step_data   <= '0;
    end else begin
      bus.step_req <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            cnt            <= 4'd2;
            bus.sched_done <= 1'b0;
            bus.key_ready  <= 1'b0;
            bus.busy       <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          // Even counts start a new 256-bit block (Rot+Sub+Rcon); odd ones are Sub only.
          bus.step_req    <= 1'b1;
          bus.step_opcode <= cnt[0];
          bus.step_rcon   <= RCON0 << ((cnt - 4'd2) >> 1);
          bus.step_data   <= {rk[cnt - 4'd2], rk[cnt - 4'd1]};
          state           <= WAIT;
        end
        WAIT: begin
          if (bus.step_ack) begin
            if (cnt == LAST) begin
              bus.sched_done <= 1'b1;
              bus.key_ready  <= 1'b1;
              bus.busy       <= 1'b0;
              state          <= DONE;
            end else begin
              cnt   <= cnt + 4'd1;
              state <= ISSUE;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rk_rd_valid <= 1'b0;
      bus.rk_rd_err   <= 1'b0;
      bus.rk_rd_data  <= '0;
    end else begin
      bus.rk_rd_valid <= 1'b0;
      bus.rk_rd_err   <= 1'b0;
      if (bus.rk_rd_en) begin
        if (rd_legal) begin
          bus.rk_rd_valid <= 1'b1;
          bus.rk_rd_data  <= rk[bus.rk_rd_idx];
        end else begin
          bus.rk_rd_err  <= 1'b1;
          bus.rk_rd_data <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: behavioural AES-256 expansion model, a randomized
// latency step unit, and random round-key reads scored against the model.
module tb_key_sched_ctrl;
  localparam int NUM_RK = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  key_sched_ctrl_if #(.WORD_LEN(32)) bus ();
  key_sched_ctrl #(.NUM_RK(NUM_RK), .WORD_LEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [127:0] ref_rk [NUM_RK];
  int written = 0;
  int step_idx = 0;
  bit auto_ack = 1'b0;
  int lat_max = 1;
  logic a_ack = 1'b0, m_ack = 1'b0;
  logic [127:0] a_res = '0, m_res = '0;

  assign bus.step_ack    = a_ack | m_ack;
  assign bus.step_result = m_ack ? m_res : a_res;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gm(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] step_fn(input logic [255:0] d, input logic op, input logic [31:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = op ? subw(d[31:0]) : (subw({d[23:0], d[31:24]}) ^ rc);
    n0 = d[255:224] ^ t;
    n1 = d[223:192] ^ n0;
    n2 = d[191:160] ^ n1;
    n3 = d[159:128] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  task automatic build_ref(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        rc = 8'h01 << (i/8 - 1);
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int n = 0; n < NUM_RK; n++) ref_rk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endtask

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic rd(input logic [3:0] idx, input string tag, output logic [127:0] got);
    logic legal;
    legal = (int'(idx) < written);
    bus.rk_rd_en = 1'b1; bus.rk_rd_idx = idx;
    tick();
    bus.rk_rd_en = 1'b0;
    got = bus.rk_rd_data;
    chk({tag, "_valid"}, bus.rk_rd_valid, legal);
    chk({tag, "_err"}, bus.rk_rd_err, !legal);
    chk({tag, "_data"}, bus.rk_rd_data, legal ? ref_rk[idx] : 128'h0);
    tick();
    chk({tag, "_pulse"}, {bus.rk_rd_valid, bus.rk_rd_err}, 2'b00);
  endtask

  task automatic read_all(input string tag);
    logic [127:0] g;
    for (int i = 0; i < 16; i++) rd(4'(i), tag, g);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.key_ready, 1'b1);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.sched_done, 1'b0);
    chk({tag, "_sreq"}, {bus.step_req, bus.step_opcode}, 2'b00);
    chk({tag, "_srcon"}, bus.step_rcon, 32'h0);
    chk({tag, "_sdata"}, bus.step_data, 256'h0);
    chk({tag, "_rd"}, {bus.rk_rd_valid, bus.rk_rd_err, bus.rk_rd_data}, 130'h0);
  endtask

  task automatic send_key(input logic [255:0] k);
    build_ref(k);
    bus.key_in = k; bus.key_valid = 1'b1;
    chk("key_ready_pre", bus.key_ready, 1'b1);
    tick();
    bus.key_valid = 1'b0;
    written = 2; step_idx = 0;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!bus.sched_done && n < bound) begin tick(); n++; end
    chk("done_seen", bus.sched_done, 1'b1);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!bus.step_req && n < 20) begin tick(); n++; end
    chk("step_req_seen", bus.step_req, 1'b1);
  endtask

  task automatic ack_manual();
    m_res = step_fn(bus.step_data, bus.step_opcode, bus.step_rcon);
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0;
    written++;
  endtask

  function automatic logic [255:0] rnd_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // Step unit: answers each request after 1..lat_max cycles and checks the request fields.
  initial begin
    logic [255:0] d;
    logic op;
    logic [31:0] rc;
    int lat, c;
    forever begin
      @(posedge clk); #1;
      if (auto_ack && bus.step_req) begin
        c = step_idx + 2;
        d = bus.step_data; op = bus.step_opcode; rc = bus.step_rcon;
        chk("step_opcode", op, c % 2);
        chk("step_rcon", rc, 32'h0100_0000 << ((c - 2) / 2));
        chk("step_data", d, {ref_rk[c-2], ref_rk[c-1]});
        lat = $urandom_range(1, lat_max);
        for (int i = 1; i < lat; i++) begin
          @(posedge clk); #1;
          chk("step_req_pulse", bus.step_req, 1'b0);
          chk("step_hold", {bus.step_opcode, bus.step_rcon, bus.step_data[127:0]}, {op, rc, d[127:0]});
        end
        a_res = step_fn(d, op, rc);
        a_ack = 1'b1;
        @(posedge clk); #1;
        a_ack = 1'b0;
        step_idx++; written++;
        chk("step_req_low", bus.step_req, 1'b0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [127:0] g;
    int n;
    bus.key_in = '0; bus.key_valid = 1'b0; bus.rk_rd_en = 1'b0; bus.rk_rd_idx = '0;
    #12;
    chk_reset_vals("rst");
    tick();
    reset = 1'b1;
    tick();
    rd(4'd0, "idle_rd", g);

    // Known-answer key, single-cycle step unit
    auto_ack = 1'b1; lat_max = 1;
    send_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    wait_done(200, n);
    chk("done_latency", n, 26);
    chk("done_status", {bus.busy, bus.key_ready}, 2'b01);
    read_all("kat");
    rd(4'd2, "kat_rk2", g);
    chk("kat_rk2_val", g, 128'ha573c29fa176c498a97fce93a572c09c);
    rd(4'd14, "kat_rk14", g);
    chk("kat_rk14_val", g, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    rd(4'd0, "kat_rk0", g);
    chk("kat_rk0_val", g, 128'h000102030405060708090a0b0c0d0e0f);

    // Restart from DONE with random latency, stray keys and reads in flight
    lat_max = 8;
    send_key(rnd_key());
    chk("restart_status", {bus.sched_done, bus.busy, bus.key_ready}, 3'b010);
    for (int i = 0; i < 3; i++) begin
      bus.key_in = rnd_key(); bus.key_valid = 1'b1;
      tick();
      chk("busy_no_ready", bus.key_ready, 1'b0);
    end
    bus.key_valid = 1'b0;
    n = 0;
    while (!bus.sched_done && n < 300) begin
      rd(4'($urandom_range(0, 15)), "fly_rd", g);
      n++;
    end
    chk("rand_done_seen", bus.sched_done, 1'b1);
    read_all("rand");

    // Manual step unit, reset while waiting on cnt=7
    auto_ack = 1'b0;
    send_key(rnd_key());
    for (int s = 0; s < 5; s++) begin
      wait_req();
      if (s == 2) begin
        rd(4'd5, "cnt4_rd5", g);
        rd(4'd3, "cnt4_rd3", g);
      end
      ack_manual();
    end
    wait_req();
    reset = 1'b0;
    #1;
    chk_reset_vals("abort");
    written = 0;
    tick();
    reset = 1'b1;
    m_res = ref_rk[7]; m_ack = 1'b1;
    tick(); tick();
    m_ack = 1'b0;
    chk_reset_vals("post_ack");
    rd(4'd0, "abort_rd", g);

    // Fresh key after abort completes normally
    auto_ack = 1'b1; lat_max = 4;
    send_key(rnd_key());
    wait_done(400, n);
    read_all("after");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/key_sched_ctrl.md
KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 SHALL have parameter NUM_RK, default 15, meaning the number of 128-bit round keys held (AES-256).
REQ-002 SHALL have parameter WORD_LEN, default 32, meaning the Rcon and word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_in, input, 256 bits: AES-256 cipher key.
REQ-006 SHALL have port key_valid, input, 1 bit: key_in is presented.
REQ-007 SHALL have port key_ready, output, 1 bit: the controller can accept a key.
REQ-008 SHALL have port step_req, output, 1 bit: one-cycle request to the shared sub-key step unit.
REQ-009 SHALL have port step_opcode, output, 1 bit: 0 = RotWord+SubWord+Rcon; 1 = SubWord only.
REQ-010 SHALL have port step_rcon, output, WORD_LEN bits: Rcon word for the step.
REQ-011 SHALL have port step_data, output, 256 bits: {RK[n-2], RK[n-1]}.
REQ-012 SHALL have port step_ack, input, 1 bit: step_result is valid this cycle.
REQ-013 SHALL have port step_result, input, 128 bits: the newly generated round key.
REQ-014 SHALL have ports rk_rd_en (input, 1 bit) and rk_rd_idx (input, 4 bits): round-key read request.
REQ-015 SHALL have ports rk_rd_data (output, 128 bits), rk_rd_valid (output, 1 bit) and rk_rd_err (output, 1 bit): read response.
REQ-016 SHALL have ports busy (output, 1 bit) and sched_done (output, 1 bit): expansion is in progress / all NUM_RK keys are valid.

Function
REQ-017 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-018 SHALL assert key_ready only in IDLE or DONE; a key is accepted on key_valid && key_ready.
REQ-019 On acceptance, SHALL write RK[0]=key_in[255:128] and RK[1]=key_in[127:0], set cnt=2, clear sched_done and go to ISSUE.
REQ-020 In ISSUE, SHALL assert step_req for exactly one cycle with:
- step_opcode = cnt[0]
- step_rcon = 32'h01000000 << ((cnt-2)>>1)
- step_data = {RK[cnt-2], RK[cnt-1]}
It then goes to WAIT.
REQ-021 SHALL hold step_opcode, step_rcon and step_data stable in WAIT until step_ack arrives.
REQ-022 In WAIT, on step_ack, SHALL write step_result to RK[cnt]:
- if cnt==NUM_RK-1, go to DONE and set sched_done on the next edge;
- otherwise increment cnt and go to ISSUE.
REQ-023 SHALL ignore step_ack in any state other than WAIT.
REQ-024 SHALL tolerate any step-unit latency; the minimum per-key period is 2 cycles, so with a 1-cycle step_ack the total is 26 cycles from acceptance to sched_done.
REQ-025 SHALL assert busy in ISSUE and WAIT and deassert it in IDLE and DONE.
REQ-026 SHALL ignore key_valid while busy; the key is neither stored nor acknowledged.
REQ-027 SHALL accept a new key in DONE, which clears sched_done in the same edge and restarts expansion at cnt=2.
REQ-028 SHALL treat a read as legal when rk_rd_idx < cnt while busy, or rk_rd_idx < NUM_RK in DONE.
REQ-029 For a legal read, SHALL register the result one cycle later: rk_rd_valid=1 and rk_rd_data=RK[idx].
REQ-030 For an illegal read (index 15, a key not yet generated, or any read in IDLE after reset), SHALL return rk_rd_valid=0, rk_rd_err=1 and rk_rd_data=0, one cycle later.
REQ-031 SHALL keep rk_rd_valid and rk_rd_err as single-cycle pulses per read request; reads are independent of the FSM and never stall it.
REQ-032 On a same-cycle write and read of RK[cnt], SHALL return the old (pre-write) content and flag the read illegal.

Reset
REQ-033 When reset is low, SHALL asynchronously set:
- state=IDLE, cnt=0
- key_ready=1, busy=0, sched_done=0
- step_req=0, step_opcode=0, step_rcon=0, step_data=0
- rk_rd_valid=0, rk_rd_err=0, rk_rd_data=0
REQ-034 SHALL treat RK storage as not requiring reset, but SHALL report no key as readable until a new key is accepted.
REQ-035 When reset is asserted mid-expansion, SHALL abort the expansion; any later step_ack is ignored.

Verification
REQ-036 Key 000102..1f, 1-cycle step model -> RK[2]=a573c29fa176c498a97fce93a572c09c; RK[14]=24fc79ccbf0979e9371ac23c6d68de36; sched_done asserted 26 cycles after acceptance.
REQ-037 Step model with random 1-8 cycle ack latency -> opcode sequence 0,1,0,1,...,0 and Rcon sequence 01,01,02,02,...,40 (<<24); results identical to REQ-036.
REQ-038 key_valid pulsed while busy -> no key_ready, no restart, final keys unchanged.
REQ-039 Read idx 5 when cnt=4 -> rk_rd_err=1, rk_rd_data=0; read idx 15 in DONE -> rk_rd_err=1; read idx 0 in DONE -> 0001..0f with rk_rd_valid=1.
REQ-040 Reset low at cnt=7 during WAIT, then step_ack -> outputs at reset values, no write; a new key then completes normally.
REQ-041 New key accepted in DONE -> sched_done drops the next cycle, busy=1, cnt=2.
